tmr_reg_scrub: RTL and testbench

- Parametrised triple-modular-redundant register bank, WIDTH bits wide.
- Bitwise majority-voted output, self-scrubbing when not written.
- Per-bit and per-lane mismatch reporting, saturating error counter, and a valid/ready error-event port.
- Sits on radiation-sensitive control and config state; the fault-injection port is for verification and for on-chip test.

---
 rtl/tmr_reg_scrub.sv | 182 ++++++++++++++++++
 tb/tb_tmr_reg_scrub.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_reg_scrub.sv
// Triple-modular-redundant register with majority vote, idle scrub,
// mismatch reporting, saturating error counter and an error-event port.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   en, d              write enable and write data
//   q                  voted register value (combinational from lanes)
//   inj_en/lane/mask   fault injection: flip mask bits in one lane
//   err_bits/lane/any  registered mismatch seen on the previous cycle
//   err_cnt, err_clr   saturating mismatch-cycle counter and its clear
//   err_valid/ready    one-entry error-event slot with handshake
//   err_ev_lane/bits   event payload, stable while err_valid
//   err_ovf            sticky: an event arrived while the slot was full
module tmr_reg_scrub #(
  parameter int               WIDTH      = 8,
  parameter bit               TRIPLICATE = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             inj_en,
  input  logic [1:0]       inj_lane,
  input  logic [WIDTH-1:0] inj_mask,
  output logic [WIDTH-1:0] err_bits,
  output logic [2:0]       err_lane,
  output logic             err_any,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [2:0]       err_ev_lane,
  output logic [WIDTH-1:0] err_ev_bits,
  output logic             err_ovf
);

  generate
    if (TRIPLICATE) begin : g_tmr
      localparam logic [CNT_W-1:0] CNT_MAX = '1;

      logic [WIDTH-1:0] l0;
      logic [WIDTH-1:0] l1;
      logic [WIDTH-1:0] l2;
      logic [WIDTH-1:0] vote;
      logic [WIDTH-1:0] nxt;
      logic [WIDTH-1:0] mm0;
      logic [WIDTH-1:0] mm1;
      logic [WIDTH-1:0] mm2;
      logic [WIDTH-1:0] m;
      logic [2:0]       mm_lane;
      logic [2:0]       sel;
      logic             hit;
      logic             pop;

      logic [WIDTH-1:0] bits_r;
      logic [2:0]       lane_r;
      logic             any_r;
      logic [CNT_W-1:0] cnt_r;
      logic             vld_r;
      logic [2:0]       ev_lane_r;
      logic [WIDTH-1:0] ev_bits_r;
      logic             ovf_r;

      assign vote = (l0 & l1) | (l1 & l2) | (l2 & l0);

      assign mm0 = l0 ^ vote;
      assign mm1 = l1 ^ vote;
      assign mm2 = l2 ^ vote;
      assign m   = mm0 | mm1 | mm2;
      assign hit = |m;

      assign mm_lane = {|mm2, |mm1, |mm0};

      // Idle cycles rewrite the voted value: this is the scrub.
      assign nxt = en ? d : vote;

      assign sel[0] = inj_en && (inj_lane == 2'd0);
      assign sel[1] = inj_en && (inj_lane == 2'd1);
      assign sel[2] = inj_en && (inj_lane == 2'd2);

      assign pop = vld_r && err_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          l0 <= RESET_VAL;
          l1 <= RESET_VAL;
          l2 <= RESET_VAL;
        end else begin
          l0 <= sel[0] ? (nxt ^ inj_mask) : nxt;
          l1 <= sel[1] ? (nxt ^ inj_mask) : nxt;
          l2 <= sel[2] ? (nxt ^ inj_mask) : nxt;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          bits_r <= '0;
          lane_r <= '0;
          any_r  <= 1'b0;
        end else begin
          bits_r <= m;
          lane_r <= mm_lane;
          any_r  <= hit;
        end
      end

      // A clear in a mismatch cycle still counts that mismatch.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_r <= '0;
        end else if (err_clr) begin
          cnt_r <= hit ? CNT_W'(1) : '0;
        end else if (hit && (cnt_r != CNT_MAX)) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end

      // One-entry slot: a new event can replace an entry leaving
      // this cycle; otherwise a full slot drops it and flags ovf.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_r     <= 1'b0;
          ev_lane_r <= '0;
          ev_bits_r <= '0;
          ovf_r     <= 1'b0;
        end else begin
          if (hit && (!vld_r || pop)) begin
            vld_r     <= 1'b1;
            ev_lane_r <= mm_lane;
            ev_bits_r <= m;
          end else if (pop) begin
            vld_r <= 1'b0;
          end
          if (hit && vld_r && !pop) begin
            ovf_r <= 1'b1;
          end else if (err_clr) begin
            ovf_r <= 1'b0;
          end
        end
      end

      assign q           = vote;
      assign err_bits    = bits_r;
      assign err_lane    = lane_r;
      assign err_any     = any_r;
      assign err_cnt     = cnt_r;
      assign err_valid   = vld_r;
      assign err_ev_lane = ev_lane_r;
      assign err_ev_bits = ev_bits_r;
      assign err_ovf     = ovf_r;
    end else begin : g_plain
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] nxt;
      logic             sel;

      assign nxt = en ? d : r;
      assign sel = inj_en && (inj_lane == 2'd0);

      always_ff @(posedge clk) begin
        if (rst) begin
          r <= RESET_VAL;
        end else begin
          r <= sel ? (nxt ^ inj_mask) : nxt;
        end
      end

      assign q           = r;
      assign err_bits    = '0;
      assign err_lane    = '0;
      assign err_any     = 1'b0;
      assign err_cnt     = '0;
      assign err_valid   = 1'b0;
      assign err_ev_lane = '0;
      assign err_ev_bits = '0;
      assign err_ovf     = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_tmr_reg_scrub.sv
// Scoreboard bench for tmr_reg_scrub: three instances (default,
// 2-bit counter, plain register) driven by shared directed stimulus.
module tb_tmr_reg_scrub;

  typedef struct packed {
    logic [2:0] lane;
    logic [7:0] bits;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] d;
  logic       inj_en;
  logic [1:0] inj_lane;
  logic [7:0] inj_mask;
  logic       err_clr;
  logic       err_ready;

  logic [7:0] q_a, bits_a, evb_a;
  logic [2:0] lane_a, evl_a;
  logic       any_a, vld_a, ovf_a;
  logic [7:0] cnt_a;

  logic [7:0] q_b, bits_b, evb_b;
  logic [2:0] lane_b, evl_b;
  logic       any_b, vld_b, ovf_b;
  logic [1:0] cnt_b;

  logic [7:0] q_c, bits_c, evb_c;
  logic [2:0] lane_c, evl_c;
  logic       any_c, vld_c, ovf_c;
  logic [7:0] cnt_c;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  tmr_reg_scrub #(
    .WIDTH(8), .TRIPLICATE(1'b1), .RESET_VAL(8'hA5), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .q(q_a),
    .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask),
    .err_bits(bits_a), .err_lane(lane_a), .err_any(any_a),
    .err_cnt(cnt_a), .err_clr(err_clr), .err_valid(vld_a),
    .err_ready(err_ready), .err_ev_lane(evl_a),
    .err_ev_bits(evb_a), .err_ovf(ovf_a)
  );

  tmr_reg_scrub #(
    .WIDTH(8), .TRIPLICATE(1'b1), .RESET_VAL(8'hA5), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst), .en(en), .d(d), .q(q_b),
    .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask),
    .err_bits(bits_b), .err_lane(lane_b), .err_any(any_b),
    .err_cnt(cnt_b), .err_clr(err_clr), .err_valid(vld_b),
    .err_ready(err_ready), .err_ev_lane(evl_b),
    .err_ev_bits(evb_b), .err_ovf(ovf_b)
  );

  tmr_reg_scrub #(
    .WIDTH(8), .TRIPLICATE(1'b0), .RESET_VAL(8'hA5), .CNT_W(8)
  ) dut3 (
    .clk(clk), .rst(rst), .en(en), .d(d), .q(q_c),
    .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask),
    .err_bits(bits_c), .err_lane(lane_c), .err_any(any_c),
    .err_cnt(cnt_c), .err_clr(err_clr), .err_valid(vld_c),
    .err_ready(err_ready), .err_ev_lane(evl_c),
    .err_ev_bits(evb_c), .err_ovf(ovf_c)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic inj(input logic [1:0] ln, input logic [7:0] mk);
    inj_en   = 1'b1;
    inj_lane = ln;
    inj_mask = mk;
  endtask

  task automatic no_inj();
    inj_en   = 1'b0;
    inj_lane = 2'd3;
    inj_mask = 8'h00;
  endtask

  // Monitor: every accepted event is popped against the scoreboard.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #2;
      if (vld_a && err_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ev_unexpected got %h exp none",
                   {evl_a, evb_a});
        end else begin
          e = exp_q.pop_front();
          chk("ev_payload", {21'd0, evl_a, evb_a}, {21'd0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    d         = 8'h00;
    err_clr   = 1'b0;
    err_ready = 1'b1;
    no_inj();

    // Reset and first write
    tick();
    chk("rst_q", q_a, 8'hA5);
    chk("rst_bits", bits_a, 8'h00);
    chk("rst_lane", lane_a, 3'b000);
    chk("rst_any", any_a, 1'b0);
    chk("rst_cnt", cnt_a, 8'd0);
    chk("rst_vld", vld_a, 1'b0);
    chk("rst_ovf", ovf_a, 1'b0);
    chk("rst_evl", evl_a, 3'b000);
    chk("rst_evb", evb_a, 8'h00);
    chk("rst_q_plain", q_c, 8'hA5);
    rst = 1'b0;
    en  = 1'b1;
    d   = 8'h3C;
    tick();
    en = 1'b0;
    chk("wr_q", q_a, 8'h3C);
    chk("wr_any", any_a, 1'b0);
    tick();
    chk("idle_q", q_a, 8'h3C);
    chk("idle_any", any_a, 1'b0);

    // Single-lane fault in lane 1
    inj(2'd1, 8'h81);
    exp_q.push_back('{lane: 3'b010, bits: 8'h81});
    tick();
    no_inj();
    chk("sl_q0", q_a, 8'h3C);
    chk("sl_l1_bad", dut.g_tmr.l1, 8'hBD);
    tick();
    chk("sl_q1", q_a, 8'h3C);
    chk("sl_bits", bits_a, 8'h81);
    chk("sl_lane", lane_a, 3'b010);
    chk("sl_any", any_a, 1'b1);
    chk("sl_cnt", cnt_a, 8'd1);
    chk("sl_vld", vld_a, 1'b1);
    chk("sl_evb", evb_a, 8'h81);
    chk("sl_evl", evl_a, 3'b010);
    chk("sl_l1_fixed", dut.g_tmr.l1, 8'h3C);
    tick();
    chk("sl_any_clr", any_a, 1'b0);
    chk("sl_vld_pop", vld_a, 1'b0);
    chk("sl_cnt_hold", cnt_a, 8'd1);

    // Lanes 0 then 2 on consecutive cycles: each scrubbed
    inj(2'd0, 8'h01);
    exp_q.push_back('{lane: 3'b001, bits: 8'h01});
    exp_q.push_back('{lane: 3'b100, bits: 8'h01});
    tick();
    inj(2'd2, 8'h01);
    tick();
    no_inj();
    chk("cons_q0", q_a, 8'h3C);
    chk("cons_lane0", lane_a, 3'b001);
    tick();
    chk("cons_q1", q_a, 8'h3C);
    chk("cons_lane2", lane_a, 3'b100);
    chk("cons_cnt", cnt_a, 8'd3);
    tick();
    chk("cons_q2", q_a, 8'h3C);
    chk("cons_any", any_a, 1'b0);

    // Same bit wrong in two lanes at once: vote goes wrong
    force dut.g_tmr.l0 = 8'h3D;
    force dut.g_tmr.l2 = 8'h3D;
    exp_q.push_back('{lane: 3'b010, bits: 8'h01});
    #1;
    chk("dbl_q_now", q_a, 8'h3D);
    tick();
    release dut.g_tmr.l0;
    release dut.g_tmr.l2;
    chk("dbl_q", q_a, 8'h3D);
    chk("dbl_lane", lane_a, 3'b010);
    chk("dbl_bits", bits_a, 8'h01);
    chk("dbl_cnt", cnt_a, 8'd4);
    tick();
    chk("dbl_q_kept", q_a, 8'h3D);
    chk("dbl_any", any_a, 1'b0);

    // Backpressure: one held event, two dropped
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("bp_cnt_clr", cnt_a, 8'd0);
    err_ready = 1'b0;
    inj(2'd0, 8'h02);
    exp_q.push_back('{lane: 3'b001, bits: 8'h02});
    tick();
    inj(2'd1, 8'h04);
    tick();
    inj(2'd2, 8'h08);
    chk("bp_vld1", vld_a, 1'b1);
    chk("bp_ovf0", ovf_a, 1'b0);
    tick();
    no_inj();
    tick();
    chk("bp_vld", vld_a, 1'b1);
    chk("bp_evl", evl_a, 3'b001);
    chk("bp_evb", evb_a, 8'h02);
    chk("bp_ovf", ovf_a, 1'b1);
    chk("bp_cnt", cnt_a, 8'd3);
    chk("bp_q", q_a, 8'h3D);
    err_ready = 1'b1;
    tick();
    chk("bp_vld_drop", vld_a, 1'b0);
    chk("bp_ovf_sticky", ovf_a, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("bp_clr_cnt", cnt_a, 8'd0);
    chk("bp_clr_ovf", ovf_a, 1'b0);

    // Saturation on the 2-bit counter
    inj(2'd0, 8'h01);
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{lane: 3'b001, bits: 8'h01});
    for (int i = 0; i < 5; i++) tick();
    no_inj();
    tick();
    chk("sat_cnt2", cnt_b, 2'd3);
    chk("sat_cnt8", cnt_a, 8'd5);
    inj(2'd1, 8'h10);
    exp_q.push_back('{lane: 3'b010, bits: 8'h10});
    tick();
    no_inj();
    chk("sat_hold", cnt_b, 2'd3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_ev_cnt2", cnt_b, 2'd1);
    chk("clr_ev_cnt8", cnt_a, 8'd1);
    tick();
    chk("q_after_sat", q_a, 8'h3D);
    chk("q_empty1", exp_q.size(), 0);

    // Reset with injection, then the plain register
    rst = 1'b1;
    inj(2'd0, 8'hFF);
    tick();
    rst = 1'b0;
    no_inj();
    chk("rinj_q", q_a, 8'hA5);
    chk("rinj_q_plain", q_c, 8'hA5);
    chk("rinj_cnt", cnt_a, 8'd0);
    en = 1'b1;
    d  = 8'h5A;
    tick();
    en = 1'b0;
    chk("pl_wr", q_c, 8'h5A);
    tick();
    chk("pl_hold", q_c, 8'h5A);
    inj(2'd0, 8'hFF);
    exp_q.push_back('{lane: 3'b001, bits: 8'hFF});
    tick();
    no_inj();
    chk("pl_inv", q_c, 8'hA5);
    chk("pl_tmr_q", q_a, 8'h5A);
    tick();
    chk("pl_inv_kept", q_c, 8'hA5);
    chk("pl_err", {bits_c, lane_c, any_c, vld_c, ovf_c, evl_c, evb_c},
        '0);
    chk("pl_cnt", cnt_c, 8'd0);
    chk("pl_tmr_lane", lane_a, 3'b001);
    inj(2'd1, 8'hFF);
    exp_q.push_back('{lane: 3'b010, bits: 8'hFF});
    tick();
    no_inj();
    chk("pl_lane1", q_c, 8'hA5);
    tick();
    tick();
    chk("pl_err2", {bits_c, lane_c, any_c, vld_c, ovf_c, evl_c, evb_c},
        '0);
    chk("q_empty2", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
